// File: rtl/irq_edge_latch_pkg.sv
// irq_edge_latch_pkg: shared constants and types for the interrupt edge latch.
// Holds register word addresses, the per-bit mode encoding and the maximum source count.
// Imported by the interface, the per-bit cell and the top level.
package irq_edge_latch_pkg;

  localparam int MAX_INTR = 32;

  localparam logic [1:0] ADDR_PENDING = 2'd0;
  localparam logic [1:0] ADDR_MASK    = 2'd1;
  localparam logic [1:0] ADDR_MODE    = 2'd2;
  localparam logic [1:0] ADDR_RAW     = 2'd3;

  typedef enum logic {
    IRQ_LEVEL = 1'b0,
    IRQ_EDGE  = 1'b1
  } irq_mode_e;

endpackage

// File: rtl/irq_edge_latch_if.sv
// irq_edge_latch_if: Avalon-MM register port of the interrupt edge latch.
// Signals: 2-bit word address, read/write strobes, 32-bit write data, 32-bit registered read data.
// Modports: master (CPU side) drives the strobes; slave (latch) returns readdata.
interface irq_edge_latch_if;
  import irq_edge_latch_pkg::*;

  logic [1:0]          avs_mem_address;
  logic                avs_mem_read;
  logic                avs_mem_write;
  logic [MAX_INTR-1:0] avs_mem_writedata;
  logic [MAX_INTR-1:0] avs_mem_readdata;

  modport master (
    output avs_mem_address,
    output avs_mem_read,
    output avs_mem_write,
    output avs_mem_writedata,
    input  avs_mem_readdata
  );

  modport slave (
    input  avs_mem_address,
    input  avs_mem_read,
    input  avs_mem_write,
    input  avs_mem_writedata,
    output avs_mem_readdata
  );

endinterface

// File: rtl/irq_edge_latch_cell.sv
// irq_edge_cell: one interrupt bit -- previous-sample flop, rising-edge detect and pending flop.
// Ports: clk/rst, conditioned source, current mode, MODE-write strobe + new mode bit, W1C clear bit;
//        outputs the previous sample (RAW) and the pending state. Pending updates on the same edge.
module irq_edge_cell
  import irq_edge_latch_pkg::*;
(
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      src_i,
  input  irq_mode_e mode_i,
  input  logic      mode_wr_i,
  input  logic      mode_wdat_i,
  input  logic      clr_i,
  output logic      prev_o,
  output logic      pending_o
);

  logic prev_q;
  logic pending_q, pending_d;
  logic edge_det;

  always_comb begin
    edge_det  = src_i & ~prev_q;
    pending_d = pending_q;
    if (mode_i == IRQ_LEVEL) begin
      // Switching level->edge starts the bit clean: no stale level, and no
      // edge is taken on the switching cycle.
      if (mode_wr_i && mode_wdat_i) pending_d = 1'b0;
      else                          pending_d = src_i;
    end else begin
      // Set wins over a same-cycle write-1-to-clear.
      pending_d = edge_det | (pending_q & ~clr_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prev_q    <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      prev_q    <= src_i;
      pending_q <= pending_d;
    end
  end

  assign prev_o    = prev_q;
  assign pending_o = pending_q;

endmodule

// File: rtl/irq_edge_latch.sv
// irq_edge_latch: conditions raw camera-pipeline interrupt sources into masked, registered level IRQs.
// Ports: clock, sync active-high reset, Avalon-MM slave (PENDING/MASK/MODE/RAW), raw sources, 32-bit irq out.
// Build option IRQ_SYNC_EN: adds a 2-flop synchronizer ahead of edge detect (src->irq 4 clks, else 2).
module irq_edge_latch
  import irq_edge_latch_pkg::*;
#(
  parameter int NUM_INTR = 32
)
(
  input  logic                 csi_mem_clock_clock,
  input  logic                 rsi_mem_reset_reset,
  irq_edge_latch_if.slave      avs,
  input  logic [NUM_INTR-1:0]  irn_source_irq,
  output logic [MAX_INTR-1:0]  ins_interrupt_irq
);

  logic                clk;
  logic                rst;
  logic [NUM_INTR-1:0] src_s;
  logic [NUM_INTR-1:0] prev_w;
  logic [NUM_INTR-1:0] pending_w;
  logic [NUM_INTR-1:0] mask_q;
  logic [NUM_INTR-1:0] mode_q;
  logic [MAX_INTR-1:0] readdata_q, readdata_d;
  logic [MAX_INTR-1:0] irq_q, irq_d;
  logic [MAX_INTR-1:0] rd_sel;
  logic                wr_pend, wr_mask, wr_mode;

  assign clk = csi_mem_clock_clock;
  assign rst = rsi_mem_reset_reset;

`ifdef IRQ_SYNC_EN
  logic [NUM_INTR-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= irn_source_irq;
      sync2_q <= sync1_q;
    end
  end

  assign src_s = sync2_q;
`else
  assign src_s = irn_source_irq;
`endif

  assign wr_pend = avs.avs_mem_write && (avs.avs_mem_address == ADDR_PENDING);
  assign wr_mask = avs.avs_mem_write && (avs.avs_mem_address == ADDR_MASK);
  assign wr_mode = avs.avs_mem_write && (avs.avs_mem_address == ADDR_MODE);

  for (genvar g = 0; g < NUM_INTR; g++) begin : g_cell
    irq_edge_cell u_cell (
      .clk_i       (clk),
      .rst_i       (rst),
      .src_i       (src_s[g]),
      .mode_i      (irq_mode_e'(mode_q[g])),
      .mode_wr_i   (wr_mode),
      .mode_wdat_i (avs.avs_mem_writedata[g]),
      .clr_i       (wr_pend & avs.avs_mem_writedata[g]),
      .prev_o      (prev_w[g]),
      .pending_o   (pending_w[g])
    );
  end

  // Read mux works on current register state, so a simultaneous write is
  // reflected only from the following read onward.
  always_comb begin
    rd_sel = '0;
    case (avs.avs_mem_address)
      ADDR_PENDING: rd_sel[NUM_INTR-1:0] = pending_w;
      ADDR_MASK:    rd_sel[NUM_INTR-1:0] = mask_q;
      ADDR_MODE:    rd_sel[NUM_INTR-1:0] = mode_q;
      default:      rd_sel[NUM_INTR-1:0] = prev_w;
    endcase
    readdata_d = avs.avs_mem_read ? rd_sel : '0;
    irq_d = '0;
    irq_d[NUM_INTR-1:0] = pending_w & mask_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mask_q     <= '0;
      mode_q     <= '1;
      readdata_q <= '0;
      irq_q      <= '0;
    end else begin
      if (wr_mask) mask_q <= avs.avs_mem_writedata[NUM_INTR-1:0];
      if (wr_mode) mode_q <= avs.avs_mem_writedata[NUM_INTR-1:0];
      readdata_q <= readdata_d;
      irq_q      <= irq_d;
    end
  end

  assign avs.avs_mem_readdata = readdata_q;
  assign ins_interrupt_irq    = irq_q;

endmodule
